// File: rtl/kernel_pr_stream_pkg.sv
// Shared constants and helpers for the kernel_pr stream adapters.
package kernel_pr_stream_pkg;

  localparam int unsigned KPR_DATA_WIDTH      = 64;
  localparam int unsigned KPR_PKT_LEN_DEFAULT = 16;
  localparam int unsigned KPR_CNT_WIDTH       = 32;

  // Packet lengths up to 2^16 beats, so the in-packet beat index fits 16 bits.
  localparam int unsigned KPR_BEAT_WIDTH = 16;

  // Output buffer occupancy: 0, 1 or 2 words.
  typedef logic [1:0] kpr_occ_t;

  localparam kpr_occ_t KPR_OCC_EMPTY = 2'd0;
  localparam kpr_occ_t KPR_OCC_ONE   = 2'd1;
  localparam kpr_occ_t KPR_OCC_FULL  = 2'd2;

  // Next in-packet beat index, wrapping after the last beat.
  function automatic logic [KPR_BEAT_WIDTH-1:0] kpr_beat_next(
    input logic [KPR_BEAT_WIDTH-1:0] beat,
    input logic [KPR_BEAT_WIDTH-1:0] last
  );
    return (beat == last) ? '0 : beat + 1'b1;
  endfunction

endpackage

// File: rtl/kernel_pr_fifo_rd_axis_skid.sv
// Two-entry in-order output buffer. slot0 is always the head word; a push
// lands in the first free slot after any same-cycle pop has shifted slot1.
module kernel_pr_fifo_rd_axis_skid
  import kernel_pr_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KPR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output kpr_occ_t              occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  kpr_occ_t              occ_q, occ_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

  // Occupancy and slot next-state for every push/pop combination.
  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (occ_q)
      KPR_OCC_EMPTY: begin
        // Nothing to pop while empty; a push is the only way to fill.
        if (push_i) begin
          slot0_d = push_data_i;
          occ_d   = KPR_OCC_ONE;
        end
      end
      KPR_OCC_ONE: begin
        if (push_i && pop_i) begin
          slot0_d = push_data_i;
        end else if (push_i) begin
          slot1_d = push_data_i;
          occ_d   = KPR_OCC_FULL;
        end else if (pop_i) begin
          occ_d = KPR_OCC_EMPTY;
        end
      end
      KPR_OCC_FULL: begin
        // The producer never pushes into a full buffer without a pop.
        if (pop_i) begin
          slot0_d = slot1_q;
          if (push_i) begin
            slot1_d = push_data_i;
          end else begin
            occ_d = KPR_OCC_ONE;
          end
        end
      end
      default: begin
        occ_d = KPR_OCC_EMPTY;
      end
    endcase
  end

  // Buffer state registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= KPR_OCC_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = slot0_q;

endmodule

// File: rtl/kernel_pr_fifo_rd_axis.sv
// Reads a show-ahead ap_fifo and streams its words out as AXI4-Stream beats,
// framing packets of PKT_LEN beats and counting beats and packets.
module kernel_pr_fifo_rd_axis
  import kernel_pr_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KPR_DATA_WIDTH,
  parameter int unsigned PKT_LEN    = KPR_PKT_LEN_DEFAULT,
  parameter int unsigned CNT_WIDTH  = KPR_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  if_empty_n,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_read,
  output logic                  if_read_ce,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  idle
);

  localparam logic [KPR_BEAT_WIDTH-1:0] LastBeat = KPR_BEAT_WIDTH'(PKT_LEN - 1);

  kpr_occ_t                  occ;
  logic                      pop;
  logic                      out;
  logic [KPR_BEAT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0]      word_q, word_d;
  logic [CNT_WIDTH-1:0]      pkt_q, pkt_d;

  // Pop gating looks only at registered occupancy, never at m_tready.
  assign pop        = reset_n & en & if_empty_n & (occ != KPR_OCC_FULL);
  assign if_read    = pop;
  assign if_read_ce = en;

  assign m_tvalid = (occ != KPR_OCC_EMPTY);
  assign out      = m_tvalid & m_tready;
  assign m_tlast  = m_tvalid & (beat_q == LastBeat);

  assign idle = ~reset_n | (~en & (occ == KPR_OCC_EMPTY));

  kernel_pr_fifo_rd_axis_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (pop),
    .push_data_i (if_dout),
    .pop_i       (out),
    .occ_o       (occ),
    .head_o      (m_tdata)
  );

  // Beat/word/packet counters advance only on a completed stream transfer.
  always_comb begin
    beat_d = beat_q;
    word_d = word_q;
    pkt_d  = pkt_q;
    if (out) begin
      beat_d = kpr_beat_next(beat_q, LastBeat);
      word_d = word_q + CNT_WIDTH'(1);
      if (m_tlast) begin
        pkt_d = pkt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Counter registers; beat_q survives en toggling so partial packets resume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      word_q <= '0;
      pkt_q  <= '0;
    end else begin
      beat_q <= beat_d;
      word_q <= word_d;
      pkt_q  <= pkt_d;
    end
  end

  assign word_cnt = word_q;
  assign pkt_cnt  = pkt_q;

endmodule

// File: tb/tb_kernel_pr_fifo_rd_axis.sv
// Directed bench: FIFO model feeds the DUT, popped words are queued as
// expectations and matched against stream beats in order.
module tb_kernel_pr_fifo_rd_axis;
  import kernel_pr_stream_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned PL = 16;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (PKT_LEN = 16)
  logic          reset_n, en, if_empty_n, m_tready;
  logic [DW-1:0] if_dout;
  logic          if_read, if_read_ce, m_tvalid, m_tlast, idle;
  logic [DW-1:0] m_tdata;
  logic [CW-1:0] word_cnt, pkt_cnt;

  // Second DUT (PKT_LEN = 1)
  logic          rst1_n, en1, if_empty_n1, m_tready1;
  logic [DW-1:0] if_dout1;
  logic          if_read1, if_read_ce1, m_tvalid1, m_tlast1, idle1;
  logic [DW-1:0] m_tdata1;
  logic [CW-1:0] word_cnt1, pkt_cnt1;

  kernel_pr_fifo_rd_axis #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .if_empty_n (if_empty_n),
    .if_dout    (if_dout),
    .if_read    (if_read),
    .if_read_ce (if_read_ce),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .word_cnt   (word_cnt),
    .pkt_cnt    (pkt_cnt),
    .idle       (idle)
  );

  kernel_pr_fifo_rd_axis #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (1),
    .CNT_WIDTH  (CW)
  ) dut1 (
    .clk        (clk),
    .reset_n    (rst1_n),
    .en         (en1),
    .if_empty_n (if_empty_n1),
    .if_dout    (if_dout1),
    .if_read    (if_read1),
    .if_read_ce (if_read_ce1),
    .m_tvalid   (m_tvalid1),
    .m_tready   (m_tready1),
    .m_tdata    (m_tdata1),
    .m_tlast    (m_tlast1),
    .word_cnt   (word_cnt1),
    .pkt_cnt    (pkt_cnt1),
    .idle       (idle1)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_q[$];

  int          total = 0;
  int          bad   = 0;
  int unsigned exp_beat, exp_words, exp_pkts;
  int unsigned out_seen, k1, extra;
  bit          gap_en, rand_ready;
  logic [DW-1:0] held, w;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    if_empty_n = (fifo_q.size() != 0) && !(gap_en && ($urandom_range(0, 3) == 0));
    if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    fifo_q.delete();
    exp_beat  = 0;
    exp_words = 0;
    exp_pkts  = 0;
  endtask

  // One clock: check at negedge, then update models/stimulus 1 after posedge.
  task automatic step();
    bit            do_pop, do_out, do_pop1;
    logic [DW-1:0] e;
    @(negedge clk);
    do_pop = if_read;
    do_out = m_tvalid && m_tready;
    chk("tvalid", m_tvalid, exp_q.size() != 0);
    chk("if_read", if_read, en && if_empty_n && (exp_q.size() < 2));
    chk("read_ce", if_read_ce, en);
    chk("tlast", m_tlast, (exp_q.size() != 0) && (exp_beat == PL - 1));
    if (do_out) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk("tdata", m_tdata, e);
      chk("word_cnt", word_cnt, exp_words);
      chk("pkt_cnt", pkt_cnt, exp_pkts);
      if (m_tlast) last_q.push_back(m_tdata);
      out_seen++;
      exp_words++;
      if (exp_beat == PL - 1) begin
        exp_beat = 0;
        exp_pkts++;
      end else begin
        exp_beat++;
      end
    end
    chk("tlast_pl1", m_tlast1, m_tvalid1);
    do_pop1 = if_read1;
    @(posedge clk);
    #1;
    if (do_pop) exp_q.push_back(fifo_q.pop_front());
    if (do_pop1) begin
      k1++;
      if_dout1 = if_dout1 + 1;
    end
    m_tready1 = 1'($urandom_range(0, 1));
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    drive_fifo();
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; m_tready = 1'b0;
    rst1_n = 1'b0; en1 = 1'b0; m_tready1 = 1'b0; if_empty_n1 = 1'b1; if_dout1 = '0;
    gap_en = 1'b0; rand_ready = 1'b0; k1 = 0; out_seen = 0;
    clear_model();
    for (int i = 1; i <= 32; i++) fifo_q.push_back(DW'(i));
    drive_fifo();

    // Reset values, with the FIFO non-empty and en high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_idle", idle, 1);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_if_read", if_read, 0);

    reset_n = 1'b1; rst1_n = 1'b1; en1 = 1'b1; m_tready = 1'b1;

    // Phase 1: 32 back-to-back beats, one-cycle latency.
    step();
    chk("first_valid", m_tvalid, 1);
    chk("first_data", m_tdata, 64'h1);
    for (int i = 0; i < 200 && out_seen < 32; i++) step();
    chk("p1_beats", out_seen, 32);
    chk("p1_word_cnt", word_cnt, 32);
    chk("p1_pkt_cnt", pkt_cnt, 2);
    chk("p1_last_n", last_q.size(), 2);
    w = (last_q.size() > 0) ? last_q[0] : '0;
    chk("p1_last0", w, 64'h10);
    w = (last_q.size() > 1) ? last_q[1] : '0;
    chk("p1_last1", w, 64'h20);

    // Phase 2: sink stalls for 5 cycles mid-stream.
    out_seen = 0;
    for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(32'h100 + i));
    drive_fifo();
    repeat (5) step();
    m_tready = 1'b0;
    step();
    held = m_tdata;
    repeat (4) step();
    chk("stall_if_read", if_read, 0);
    chk("stall_tvalid", m_tvalid, 1);
    chk("stall_hold", m_tdata, held);
    m_tready = 1'b1;
    for (int i = 0; i < 200 && out_seen < 20; i++) step();
    chk("p2_beats", out_seen, 20);

    // Phase 3: asynchronous reset with a full buffer.
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'h300 + i));
    drive_fifo();
    m_tready = 1'b0;
    repeat (4) step();
    chk("pre_rst_full", if_read, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_tvalid", m_tvalid, 0);
    chk("arst_word_cnt", word_cnt, 0);
    chk("arst_pkt_cnt", pkt_cnt, 0);
    chk("arst_if_read", if_read, 0);
    clear_model();
    drive_fifo();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Phase 4: 1000 random words, random gaps and backpressure.
    en1 = 1'b0;
    out_seen = 0;
    for (int i = 0; i < 1000; i++) fifo_q.push_back({$urandom, $urandom});
    gap_en = 1'b1;
    rand_ready = 1'b1;
    drive_fifo();
    for (int i = 0; i < 20000 && out_seen < 1000; i++) step();
    gap_en = 1'b0;
    rand_ready = 1'b0;
    m_tready = 1'b1;
    chk("p4_beats", out_seen, 1000);
    chk("p4_word_cnt", word_cnt, 1000);
    chk("p4_pkt_cnt", pkt_cnt, 62);
    chk("p4_drained", exp_q.size(), 0);

    // Phase 5: en dropped mid-packet, then resumed.
    reset_n = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_seen = 0;
    for (int i = 1; i <= 40; i++) fifo_q.push_back(DW'(32'h200 + i));
    drive_fifo();
    for (int i = 0; i < 100 && out_seen < 10; i++) step();
    en = 1'b0;
    repeat (6) step();
    extra = out_seen - 10;
    chk("en_drop_le2", extra <= 2, 1);
    chk("en_drop_words", word_cnt, 10 + extra);
    chk("en_drop_idle", idle, 1);
    chk("en_drop_tvalid", m_tvalid, 0);
    chk("en_drop_if_read", if_read, 0);
    en = 1'b1;
    last_q.delete();
    for (int i = 0; i < 100 && out_seen < 16; i++) step();
    chk("p5_last_n", last_q.size(), 1);
    w = (last_q.size() > 0) ? last_q[0] : '0;
    chk("p5_last_data", w, 64'h210);
    for (int i = 0; i < 200 && out_seen < 40; i++) step();
    chk("p5_beats", out_seen, 40);

    // PKT_LEN = 1 instance: every beat closes a packet.
    chk("pl1_active", k1 > 0, 1);
    chk("pl1_drained", m_tvalid1, 0);
    chk("pl1_word_cnt", word_cnt1, k1);
    chk("pl1_pkt_cnt", pkt_cnt1, k1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
